// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART frame controller: frame state encoding,
// start-of-frame marker, error-bit positions and the checksum helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Frame parser states; encodings 3'd6 and 3'd7 are unused.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_HOLD    = 3'd5
    } frame_state_e;

    // Start-of-frame marker byte.
    localparam logic [7:0] SOF = 8'hA5;

    // Bit positions inside the 4-bit error pulse vector.
    localparam int ERR_CHECKSUM = 0;
    localparam int ERR_LENGTH   = 1;
    localparam int ERR_OVERRUN  = 2;
    localparam int ERR_TIMEOUT  = 3;

    // Running checksum step: the frame checksum is a plain byte-wise XOR.
    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_frame_ctrl
// Parses byte-serial frames  SOF(A5) CMD LEN PAYLOAD[LEN] CHK  coming from a
// UART receiver, verifies CHK (XOR of CMD, LEN and payload) and holds a good
// frame on its outputs until the consumer accepts it.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   i_byte_valid   one-cycle strobe: i_byte_data holds a received byte
//   i_byte_data    received byte
//   o_frame_valid  a checked frame is held on o_cmd/o_len/o_payload
//   i_frame_ready  consumer accepts the held frame when o_frame_valid=1
//   o_cmd          command byte
//   o_len          payload length
//   o_payload      payload, byte k at [8k+7:8k], bytes >= o_len read zero
//   o_err          one-cycle pulses {timeout, overrun, length, checksum}
//   t_state        current parser state (debug)
//
// Optional feature: define UART_FRAME_TIMEOUT_EN to abandon a partial frame
// (with an o_err[3] pulse) when the gap between bytes reaches
// TIMEOUT_BITS bit periods. Without it o_err[3] is constant zero and a
// partial frame waits indefinitely.
// -----------------------------------------------------------------------------
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD         = 9600,
    parameter int CLK_F        = 50_000_000,
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_byte_valid,
    input  logic [7:0]           i_byte_data,
    output logic                 o_frame_valid,
    input  logic                 i_frame_ready,
    output logic [7:0]           o_cmd,
    output logic [7:0]           o_len,
    output logic [8*MAX_LEN-1:0] o_payload,
    output logic [3:0]           o_err,
    output logic [2:0]           t_state
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    frame_state_e         state_q;
    logic [7:0]           idx_q;
    logic [7:0]           xor_q;
    logic [7:0]           xor_d;
    logic                 valid_q;
    logic [7:0]           cmd_q;
    logic [7:0]           len_q;
    logic [8*MAX_LEN-1:0] payload_q;
    logic [3:0]           err_q;
    logic                 last_byte_s;

    // Checksum next value and "this is the final payload byte" decode.
    always_comb begin
        xor_d       = chk_update(xor_q, i_byte_data);
        last_byte_s = (idx_q == (len_q - 8'd1));
    end

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TO_RAW = TIMEOUT_BITS * CLK_F / BAUD;
    localparam int TO_W   = (TO_RAW > 1) ? $clog2(TIMEOUT_BITS * CLK_F / BAUD) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_BITS * (CLK_F / BAUD) - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;
    logic            in_frame_s;
    logic            to_hit_s;

    // Gap counter runs only while a frame is partially received; any byte
    // strobe restarts it, and a strobe wins over an expiring count.
    always_comb begin
        in_frame_s = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                     (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
        to_hit_s   = in_frame_s && !i_byte_valid && (to_cnt_q == TO_LIMIT);
        if (!in_frame_s || i_byte_valid || to_hit_s) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Inter-byte gap counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    // Timing parameters only matter for the optional gap timeout.
    logic [31:0] cfg_unused_s;
    assign cfg_unused_s = 32'(TIMEOUT_BITS) ^ 32'(CLK_F) ^ 32'(BAUD);
`endif

    // Frame parser FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 8'd0;
            xor_q     <= 8'd0;
            valid_q   <= 1'b0;
            cmd_q     <= 8'd0;
            len_q     <= 8'd0;
            payload_q <= '0;
            err_q     <= 4'd0;
        end else begin
            err_q <= 4'd0;
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (i_byte_valid && (i_byte_data == SOF)) begin
                        // Clearing here makes unused payload bytes read zero.
                        payload_q <= '0;
                        idx_q     <= 8'd0;
                        xor_q     <= 8'd0;
                        state_q   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (i_byte_valid) begin
                        cmd_q   <= i_byte_data;
                        xor_q   <= i_byte_data;
                        state_q <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (i_byte_valid) begin
                        if (i_byte_data > MAX_LEN_B) begin
                            err_q[ERR_LENGTH] <= 1'b1;
                            state_q           <= ST_IDLE;
                        end else begin
                            len_q   <= i_byte_data;
                            xor_q   <= xor_d;
                            idx_q   <= 8'd0;
                            state_q <= (i_byte_data == 8'd0) ? ST_CHECK : ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (i_byte_valid) begin
                        payload_q[{idx_q, 3'b000} +: 8] <= i_byte_data;
                        idx_q <= idx_q + 8'd1;
                        xor_q <= xor_d;
                        if (last_byte_s) begin
                            state_q <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (i_byte_valid) begin
                        if (i_byte_data == xor_q) begin
                            valid_q <= 1'b1;
                            state_q <= ST_HOLD;
                        end else begin
                            err_q[ERR_CHECKSUM] <= 1'b1;
                            state_q             <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    // Bytes arriving while a frame is held are lost, even on
                    // the handshake cycle; nothing new is started from them.
                    if (i_byte_valid) begin
                        err_q[ERR_OVERRUN] <= 1'b1;
                    end
                    if (valid_q && i_frame_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    idx_q     <= 8'd0;
                    xor_q     <= 8'd0;
                    valid_q   <= 1'b0;
                    cmd_q     <= 8'd0;
                    len_q     <= 8'd0;
                    payload_q <= '0;
                    err_q     <= 4'd0;
                end
            endcase
`ifdef UART_FRAME_TIMEOUT_EN
            // Only fires without a strobe, so it never collides with the case above.
            if (to_hit_s) begin
                err_q[ERR_TIMEOUT] <= 1'b1;
                state_q            <= ST_IDLE;
            end
`endif
        end
    end

    assign o_frame_valid = valid_q;
    assign o_cmd         = cmd_q;
    assign o_len         = len_q;
    assign o_payload     = payload_q;
    assign o_err         = err_q;
    assign t_state       = state_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_ctrl
// Self-checking bench for uart_frame_ctrl. A byte-queue reference model
// decides frame outcomes from the frame format rules; directed frames cover
// the worked examples, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_uart_frame_ctrl;
    import uart_pkg::*;

    localparam int MAX_LEN = 16;
`ifdef UART_FRAME_TIMEOUT_EN
    localparam int CLK_F   = 1000;
    localparam int BAUD    = 100;
    localparam int TO_BITS = 2;
    localparam int TO_CYCLES = TO_BITS * (CLK_F / BAUD);
`else
    localparam int CLK_F   = 50_000_000;
    localparam int BAUD    = 9600;
    localparam int TO_BITS = 20;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 byte_valid = 1'b0;
    logic [7:0]           byte_data = 8'd0;
    logic                 frame_ready = 1'b0;
    logic                 frame_valid;
    logic [7:0]           cmd;
    logic [7:0]           len;
    logic [8*MAX_LEN-1:0] payload;
    logic [3:0]           err;
    logic [2:0]           state;

    uart_frame_ctrl #(
        .BAUD(BAUD), .CLK_F(CLK_F), .MAX_LEN(MAX_LEN), .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_byte_valid(byte_valid), .i_byte_data(byte_data),
        .o_frame_valid(frame_valid), .i_frame_ready(frame_ready),
        .o_cmd(cmd), .o_len(len), .o_payload(payload),
        .o_err(err), .t_state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: bytes of the frame collected so far plus the held frame.
    logic [7:0]   mq[$];
    bit           m_held = 1'b0;
    logic [7:0]   m_cmd = 8'd0;
    logic [7:0]   m_len = 8'd0;
    logic [127:0] m_pay = '0;
    logic [3:0]   m_err = 4'd0;
    int           m_gap = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_held = 1'b0;
        m_err  = 4'd0;
        m_gap  = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic r);
        logic [7:0] x;
        m_err = 4'd0;
        if (m_held) begin
            if (v) m_err[ERR_OVERRUN] = 1'b1;
            if (r) m_held = 1'b0;
        end else if (v) begin
            m_gap = 0;
            if (mq.size() == 0) begin
                if (d == SOF) mq.push_back(d);
            end else begin
                mq.push_back(d);
                if (mq.size() == 3 && int'(d) > MAX_LEN) begin
                    m_err[ERR_LENGTH] = 1'b1;
                    mq.delete();
                end else if (mq.size() >= 3 && mq.size() == int'(mq[2]) + 4) begin
                    x = 8'd0;
                    for (int k = 1; k < mq.size() - 1; k++) x = x ^ mq[k];
                    if (x == d) begin
                        m_held = 1'b1;
                        m_cmd  = mq[1];
                        m_len  = mq[2];
                        m_pay  = '0;
                        for (int k = 0; k < int'(mq[2]); k++) m_pay[8*k +: 8] = mq[3+k];
                    end else begin
                        m_err[ERR_CHECKSUM] = 1'b1;
                    end
                    mq.delete();
                end
            end
        end
`ifdef UART_FRAME_TIMEOUT_EN
        else if (mq.size() != 0) begin
            m_gap++;
            if (m_gap == TO_CYCLES) begin
                m_err[ERR_TIMEOUT] = 1'b1;
                mq.delete();
                m_gap = 0;
            end
        end
`endif
    endtask

    task automatic compare_outputs();
        check_eq("err", err, m_err);
        check_eq("frame_valid", frame_valid, m_held);
        if (m_held) begin
            check_eq("cmd", cmd, m_cmd);
            check_eq("len", len, m_len);
            check_eq("payload", payload, m_pay);
            check_eq("state_hold", state, ST_HOLD);
        end else if (mq.size() == 0) begin
            check_eq("state_idle", state, ST_IDLE);
        end
    endtask

    // One clock: drive at the falling edge, sample at the next falling edge.
    task automatic tick(input logic v, input logic [7:0] d, input logic r);
        byte_valid  = v;
        byte_data   = d;
        frame_ready = r;
        model_step(v, d, r);
        @(posedge clk);
        @(negedge clk);
        byte_valid  = 1'b0;
        frame_ready = 1'b0;
        compare_outputs();
    endtask

    task automatic send_bytes(input logic [7:0] q[$]);
        foreach (q[i]) tick(1'b1, q[i], 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_err", err, 4'd0);
        check_eq("rst_valid", frame_valid, 1'b0);
        check_eq("rst_state", state, ST_IDLE);
        check_eq("rst_cmd", cmd, 8'd0);
        check_eq("rst_len", len, 8'd0);
        check_eq("rst_payload", payload, 128'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] fq[$];
        logic [7:0] x;
        int kind;
        int flen;
        int hits;
        @(negedge clk);
        do_reset();
        tick(1'b0, 8'd0, 1'b0);

        // Two-byte payload frame.
        send_bytes('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
        check_eq("ex1_valid", frame_valid, 1'b1);
        check_eq("ex1_payload", payload, 128'h2211);
        tick(1'b0, 8'd0, 1'b1);

        // Empty frame held with consumer stalled for 50 cycles.
        send_bytes('{8'hA5, 8'h20, 8'h00, 8'h20});
        for (int i = 0; i < 50; i++) tick(1'b0, 8'd0, 1'b0);
        check_eq("stall_cmd", cmd, 8'h20);
        tick(1'b0, 8'd0, 1'b1);
        check_eq("stall_release", frame_valid, 1'b0);

        // Bad checksum.
        send_bytes('{8'hA5, 8'h10, 8'h01, 8'h55, 8'h00});
        check_eq("bad_chk_err", err, 4'b0001);
        tick(1'b0, 8'd0, 1'b0);

        // Over-long length, then a normal frame.
        send_bytes('{8'hA5, 8'h10, 8'(MAX_LEN + 1)});
        check_eq("len_err", err, 4'b0010);
        send_bytes('{8'hA5, 8'h07, 8'h01, 8'h3C, 8'h3A});
        check_eq("len_recover", frame_valid, 1'b1);

        // Extra byte while held, then one on the handshake cycle.
        tick(1'b1, 8'h33, 1'b0);
        check_eq("overrun_err", err, 4'b0100);
        tick(1'b1, 8'hA5, 1'b1);
        check_eq("overrun_hs_err", err, 4'b0100);
        tick(1'b1, 8'h10, 1'b0);

        // Reset in the middle of a frame and during hold: no error pulses.
        send_bytes('{8'hA5, 8'h10});
        do_reset();
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'h01});
        do_reset();
        tick(1'b0, 8'd0, 1'b0);

`ifdef UART_FRAME_TIMEOUT_EN
        // Lone SOF followed by silence: timeout pulse after the gap limit.
        tick(1'b1, 8'hA5, 1'b0);
        hits = 0;
        for (int i = 1; i <= TO_CYCLES + 5; i++) begin
            tick(1'b0, 8'd0, 1'b0);
            if (err[ERR_TIMEOUT] && hits == 0) begin
                hits = i;
                check_eq("timeout_err", err, 4'b1000);
            end
        end
        check_eq("timeout_latency", hits, 20);
`endif

        // Randomized traffic.
        for (int f = 0; f < 200; f++) begin
            fq.delete();
            kind = $urandom_range(0, 5);
            if (kind == 4) begin
                x = 8'($urandom_range(0, 255));
                if (x == SOF) x = 8'h00;
                fq.push_back(x);
            end else begin
                if (kind == 3) flen = $urandom_range(MAX_LEN + 1, 255);
                else           flen = $urandom_range(0, MAX_LEN);
                fq.push_back(SOF);
                fq.push_back(8'($urandom_range(0, 255)));
                fq.push_back(8'(flen));
                x = fq[1] ^ fq[2];
                if (kind != 3) begin
                    for (int k = 0; k < flen; k++) begin
                        fq.push_back(8'($urandom_range(0, 255)));
                        x = x ^ fq[fq.size()-1];
                    end
                    if (kind == 2) x = x ^ 8'(1 << $urandom_range(0, 7));
                    fq.push_back(x);
                end
            end
            foreach (fq[i]) begin
                tick(1'b1, fq[i], ($urandom_range(0, 3) == 0));
                for (int g = $urandom_range(0, 2); g > 0; g--)
                    tick(1'b0, 8'd0, ($urandom_range(0, 3) == 0));
            end
            for (int g = $urandom_range(0, 4); g > 0; g--)
                tick(1'b0, 8'd0, ($urandom_range(0, 1) == 0));
        end

        for (int i = 0; i < 4; i++) tick(1'b0, 8'd0, 1'b1);
        check_eq("drain_valid", frame_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter BAUD, default 9600, serial bit rate used for timeout scaling.
REQ-002 SHALL have parameter CLK_F, default 50_000_000, clock frequency in Hz.
REQ-003 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame (1..255).
REQ-004 SHALL have parameter TIMEOUT_BITS, default 20, inter-byte gap limit in bit periods.
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_byte_valid  input  1  one-cycle strobe from UART receiver: byte available.
REQ-008 SHALL have port i_byte_data  input  8  received byte, sampled when i_byte_valid=1.
REQ-009 SHALL have port o_frame_valid  output  1  complete, checksum-correct frame held on outputs.
REQ-010 SHALL have port i_frame_ready  input  1  consumer accepts frame when o_frame_valid=1.
REQ-011 SHALL have port o_cmd  output  8  frame command byte.
REQ-012 SHALL have port o_len  output  8  frame payload length.
REQ-013 SHALL have port o_payload  output  8*MAX_LEN  payload, byte k at bits [8k+7:8k].
REQ-014 SHALL have port o_err  output  4  one-cycle error pulses {timeout, overrun, length, checksum} (bit 3..0).
REQ-015 SHALL have port t_state  output  3  current state, debug.

Function
REQ-016 Frame format SHALL be: SOF (8'hA5), CMD, LEN, LEN payload bytes, CHK; CHK = XOR of CMD, LEN and all payload bytes.
REQ-017 States SHALL be IDLE, CMD, LEN, PAYLOAD, CHECK, HOLD; one byte consumed per i_byte_valid strobe.
REQ-018 IDLE: byte==8'hA5 -> CMD; any other byte ignored, no error.
REQ-019 CMD: store byte in o_cmd, seed running XOR -> LEN.
REQ-020 LEN: LEN>MAX_LEN -> o_err[1] pulse, IDLE; LEN==0 -> CHECK; else -> PAYLOAD, byte index cleared.
REQ-021 PAYLOAD: store byte at index, index+1, XOR update; after byte LEN-1 -> CHECK.
REQ-022 CHECK: byte==running XOR -> HOLD, o_frame_valid=1 the cycle after the CHK strobe; mismatch -> o_err[0] pulse, IDLE.
REQ-023 HOLD: o_frame_valid, o_cmd, o_len, o_payload SHALL stay stable until o_frame_valid & i_frame_ready; next cycle o_frame_valid=0, state IDLE.
REQ-024 Any byte strobe in HOLD, including the handshake cycle, SHALL be dropped with o_err[2] pulse; no partial frame started.
REQ-025 Payload bytes at index >= LEN SHALL read 8'h00 in HOLD (buffer cleared on SOF acceptance).
REQ-026 Error pulses SHALL last exactly one cycle and be registered.
REQ-027 Unused state encodings SHALL return to IDLE with outputs at reset values.

Reset
REQ-028 On rst_n=0: state IDLE, o_frame_valid=0, o_cmd=0, o_len=0, o_payload=0, o_err=0, index/XOR/timeout counter 0.
REQ-029 Reset mid-frame or in HOLD SHALL discard the frame without any error pulse.

Configuration
REQ-030 With UART_FRAME_TIMEOUT_EN defined: counter of width $clog2(TIMEOUT_BITS*CLK_F/BAUD) runs in CMD, LEN, PAYLOAD, CHECK, cleared on each byte strobe; reaching TIMEOUT_BITS*(CLK_F/BAUD)-1 -> o_err[3] pulse, IDLE.
REQ-031 Without UART_FRAME_TIMEOUT_EN: no counter synthesized, o_err[3] tied 0, partial frame waits indefinitely.

Structure
REQ-032 Shared package uart_pkg SHALL hold the frame state enum, SOF constant 8'hA5 and error-bit index constants.
REQ-033 No sub-module; block sits beside the UART receiver at top level, its o_valid/o_rx_data driving i_byte_valid/i_byte_data.

Verification
REQ-034 Bytes A5,10,02,11,22,CHK=21 -> o_frame_valid=1 next cycle, o_cmd=10, o_len=2, payload[15:0]=16'h2211, rest 0.
REQ-035 A5,20,00,CHK=20 with i_frame_ready low 50 cycles -> outputs stable 50 cycles, clear one cycle after ready.
REQ-036 A5,10,01,55,CHK=00 -> o_err=4'b0001 for one cycle, no o_frame_valid, state IDLE.
REQ-037 A5,10,LEN=MAX_LEN+1 -> o_err=4'b0010; following valid frame accepted normally.
REQ-038 Frame held, extra byte 33 strobed -> o_err=4'b0100, held outputs unchanged.
REQ-039 Macro defined, CLK_F=1000, BAUD=100, TIMEOUT_BITS=2: A5 then silence -> o_err=4'b1000 exactly 20 cycles after A5 strobe.
